// File: rtl/rgmii_speed_ctrl.sv
// RGMII receive link-speed controller: debounces the in-band status nibble seen
// in inter-frame gaps and sequences a glitch-safe speed-select change.
module rgmii_speed_ctrl #(
    parameter int STABLE_CNT = 16,
    parameter int IDLE_CNT   = 64,
    parameter int HOLD_CNT   = 8
) (
    input  logic       clk_div,
    input  logic       reset,
    input  logic [7:0] rxd_in,
    input  logic       rxdv_in,
    input  logic       rxer_in,
    input  logic       force_en,
    input  logic [1:0] force_speed,
    output logic       speed,
    output logic       dp_reset,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       full_duplex,
    output logic       status_valid,
    output logic       speed_changed
);
    localparam int SW = $clog2(STABLE_CNT);
    localparam int IW = $clog2(IDLE_CNT + 1);
    localparam int HW = $clog2(HOLD_CNT + 1);

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        WAIT_IDLE = 3'd1,
        PRE_RST   = 3'd2,
        SWAP      = 3'd3,
        POST_RST  = 3'd4
    } state_t;

    logic [7:0]    rxd_m_q, rxd_s_q;
    logic          rxdv_m_q, rxdv_s_q, rxer_m_q, rxer_s_q;
    state_t        state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          speed_q, speed_d, dp_reset_q, dp_reset_d;
    logic          link_up_q, link_up_d, full_duplex_q, full_duplex_d;
    logic [1:0]    link_speed_q, link_speed_d;
    logic          status_valid_q, status_valid_d;
    logic          speed_changed_q, speed_changed_d;
    logic          pulse_arm_q, pulse_arm_d;
    logic [3:0]    nib_s;
    logic          sample_s, target_s;

    // Two-flop synchroniser for the quasi-static receiver outputs
    always_ff @(posedge clk_div or posedge reset) begin
        if (reset) begin
            rxd_m_q  <= 8'h00;
            rxd_s_q  <= 8'h00;
            rxdv_m_q <= 1'b0;
            rxdv_s_q <= 1'b0;
            rxer_m_q <= 1'b0;
            rxer_s_q <= 1'b0;
        end else begin
            rxd_m_q  <= rxd_in;
            rxd_s_q  <= rxd_m_q;
            rxdv_m_q <= rxdv_in;
            rxdv_s_q <= rxdv_m_q;
            rxer_m_q <= rxer_in;
            rxer_s_q <= rxer_m_q;
        end
    end

    // Nibble layout: [0]=link, [2:1]=speed, [3]=duplex; frozen while the datapath is in reset
    assign nib_s    = rxd_s_q[7:4];
    assign sample_s = !rxdv_s_q && !rxer_s_q && !dp_reset_q;

    // Debounce candidate/counter and commit of link status
    always_comb begin
        cand_d         = cand_q;
        cnt_d          = cnt_q;
        link_up_d      = link_up_q;
        link_speed_d   = link_speed_q;
        full_duplex_d  = full_duplex_q;
        status_valid_d = status_valid_q;
        if (sample_s) begin
            if (nib_s == cand_q) begin
                if (cnt_q != SW'(STABLE_CNT - 1)) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = cnt_q;
                end
            end else begin
                cand_d = nib_s;
                cnt_d  = '0;
            end
        end else begin
            cnt_d = cnt_q;
        end
        // First commit is forced even if the candidate equals the reset status
        if (!dp_reset_q && (cnt_q == SW'(STABLE_CNT - 1)) &&
            ((cand_q != {full_duplex_q, link_speed_q, link_up_q}) || !status_valid_q)) begin
            link_up_d      = cand_q[0];
            full_duplex_d  = cand_q[3];
            status_valid_d = 1'b1;
            if (cand_q[2:1] != 2'b11) begin
                link_speed_d = cand_q[2:1];
            end else begin
                link_speed_d = link_speed_q;
            end
        end else begin
            status_valid_d = status_valid_q;
        end
    end

    // Reserved forced code and link-down both leave 1000M deselected / unchanged
    assign target_s = force_en ? (force_speed == 2'b10)
                               : (link_up_q ? (link_speed_q == 2'b10) : speed_q);

    // Speed-switch sequencer: next state and registered outputs
    always_comb begin
        state_d         = state_q;
        idle_d          = idle_q;
        hold_d          = hold_q;
        speed_d         = speed_q;
        pulse_arm_d     = pulse_arm_q;
        speed_changed_d = 1'b0;
        case (state_q)
            RUN: begin
                if (target_s != speed_q) begin
                    state_d = WAIT_IDLE;
                    idle_d  = '0;
                end else begin
                    state_d = RUN;
                end
            end
            WAIT_IDLE: begin
                if (target_s == speed_q) begin
                    state_d = RUN;
                end else if (rxdv_s_q) begin
                    idle_d = '0;
                end else if (idle_q == IW'(IDLE_CNT - 1)) begin
                    state_d = PRE_RST;
                    hold_d  = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            PRE_RST: begin
                if (hold_q == HW'(HOLD_CNT - 1)) begin
                    state_d = SWAP;
                    speed_d = target_s;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            SWAP: begin
                state_d     = POST_RST;
                hold_d      = '0;
                pulse_arm_d = 1'b1;
            end
            POST_RST: begin
                if (hold_q == HW'(HOLD_CNT - 1)) begin
                    state_d         = RUN;
                    speed_changed_d = pulse_arm_q;
                    pulse_arm_d     = 1'b0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d     = POST_RST;
                hold_d      = '0;
                pulse_arm_d = 1'b0;
            end
        endcase
        dp_reset_d = (state_d == PRE_RST) || (state_d == SWAP) || (state_d == POST_RST);
    end

    // State and output registers; reset parks the datapath in reset at 10/100
    always_ff @(posedge clk_div or posedge reset) begin
        if (reset) begin
            state_q         <= POST_RST;
            cnt_q           <= '0;
            cand_q          <= 4'h0;
            idle_q          <= '0;
            hold_q          <= '0;
            speed_q         <= 1'b0;
            dp_reset_q      <= 1'b1;
            link_up_q       <= 1'b0;
            link_speed_q    <= 2'b00;
            full_duplex_q   <= 1'b0;
            status_valid_q  <= 1'b0;
            speed_changed_q <= 1'b0;
            pulse_arm_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            cand_q          <= cand_d;
            idle_q          <= idle_d;
            hold_q          <= hold_d;
            speed_q         <= speed_d;
            dp_reset_q      <= dp_reset_d;
            link_up_q       <= link_up_d;
            link_speed_q    <= link_speed_d;
            full_duplex_q   <= full_duplex_d;
            status_valid_q  <= status_valid_d;
            speed_changed_q <= speed_changed_d;
            pulse_arm_q     <= pulse_arm_d;
        end
    end

    assign speed         = speed_q;
    assign dp_reset      = dp_reset_q;
    assign link_up       = link_up_q;
    assign link_speed    = link_speed_q;
    assign full_duplex   = full_duplex_q;
    assign status_valid  = status_valid_q;
    assign speed_changed = speed_changed_q;
endmodule

// File: tb/tb_rgmii_speed_ctrl.sv
// Directed, table-driven bench for rgmii_speed_ctrl with hand-written
// sequences for debounce rejection, frame-blocked switching and mid-switch reset.
module tb_rgmii_speed_ctrl;
    logic       clk_div = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rxd_in = 8'h00;
    logic       rxdv_in = 1'b0;
    logic       rxer_in = 1'b0;
    logic       force_en = 1'b0;
    logic [1:0] force_speed = 2'b00;
    logic       speed, dp_reset, link_up, full_duplex, status_valid, speed_changed;
    logic [1:0] link_speed;

    int n_tests = 0;
    int n_fail = 0;
    int dp_total = 0;
    int sc_total = 0;
    int sc_double = 0;
    logic sc_prev = 1'b0;

    rgmii_speed_ctrl dut (
        .clk_div(clk_div), .reset(reset), .rxd_in(rxd_in), .rxdv_in(rxdv_in),
        .rxer_in(rxer_in), .force_en(force_en), .force_speed(force_speed),
        .speed(speed), .dp_reset(dp_reset), .link_up(link_up),
        .link_speed(link_speed), .full_duplex(full_duplex),
        .status_valid(status_valid), .speed_changed(speed_changed)
    );

    always #5 clk_div = ~clk_div;

    // Count dp_reset-high cycles and speed_changed pulses on the inactive edge
    always @(negedge clk_div) begin
        if (dp_reset) dp_total <= dp_total + 1;
        if (speed_changed) sc_total <= sc_total + 1;
        if (speed_changed && sc_prev) sc_double <= sc_double + 1;
        sc_prev <= speed_changed;
    end

    typedef struct {
        logic [3:0] nib;
        logic       er;
        logic       fen;
        logic [1:0] fsp;
        int         cyc;
        logic       e_speed;
        logic       e_link;
        logic [1:0] e_ls;
        logic       e_fd;
        logic       e_sv;
        int         e_dp;
        int         e_sc;
    } vec_t;

    vec_t rows[7];

    task automatic step(input int n);
        repeat (n) @(posedge clk_div);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    initial begin
        int dp0, sc0;
        logic seen;

        //            nib   er    fen   fsp    cyc  spd   lnk   ls     fd    sv    dp  sc
        rows[0] = '{4'h0, 1'b0, 1'b0, 2'b00,  40, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1,  0, 0};
        rows[1] = '{4'hD, 1'b0, 1'b0, 2'b00, 200, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 17, 1};
        rows[2] = '{4'h3, 1'b0, 1'b0, 2'b00, 200, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 17, 1};
        rows[3] = '{4'h3, 1'b0, 1'b1, 2'b10, 200, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 17, 1};
        rows[4] = '{4'h3, 1'b0, 1'b0, 2'b00, 200, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 17, 1};
        rows[5] = '{4'h3, 1'b0, 1'b1, 2'b11, 200, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1,  0, 0};
        rows[6] = '{4'hD, 1'b1, 1'b0, 2'b00, 100, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1,  0, 0};

        // Reset values, then the post-release hold window
        step(3);
        chk("rst_speed", speed, 0);
        chk("rst_dp_reset", dp_reset, 1);
        chk("rst_link_up", link_up, 0);
        chk("rst_link_speed", link_speed, 0);
        chk("rst_full_duplex", full_duplex, 0);
        chk("rst_status_valid", status_valid, 0);
        chk("rst_speed_changed", speed_changed, 0);
        reset = 1'b0;
        dp0 = dp_total;
        sc0 = sc_total;
        for (int i = 0; i < 50 && dp_reset; i++) step(1);
        chk("rel_dp_low", dp_reset, 0);
        chk("rel_hold_cycles", dp_total - dp0, 8);
        chk("rel_no_pulse", sc_total - sc0, 0);

        // Table vectors: steady in-band/force inputs for a fixed window
        for (int i = 0; i < 7; i++) begin
            rxd_in      = {rows[i].nib, 4'h0};
            rxdv_in     = 1'b0;
            rxer_in     = rows[i].er;
            force_en    = rows[i].fen;
            force_speed = rows[i].fsp;
            dp0 = dp_total;
            sc0 = sc_total;
            step(rows[i].cyc);
            chk($sformatf("row%0d_speed", i), speed, rows[i].e_speed);
            chk($sformatf("row%0d_link_up", i), link_up, rows[i].e_link);
            chk($sformatf("row%0d_link_speed", i), link_speed, rows[i].e_ls);
            chk($sformatf("row%0d_full_duplex", i), full_duplex, rows[i].e_fd);
            chk($sformatf("row%0d_status_valid", i), status_valid, rows[i].e_sv);
            chk($sformatf("row%0d_dp_cycles", i), dp_total - dp0, rows[i].e_dp);
            chk($sformatf("row%0d_pulses", i), sc_total - sc0, rows[i].e_sc);
            chk($sformatf("row%0d_dp_now", i), dp_reset, 0);
        end
        rxer_in  = 1'b0;
        force_en = 1'b0;

        // Alternating 0xD/0x1 every 10 samples never reaches the stable count
        dp0 = dp_total;
        for (int k = 0; k < 20; k++) begin
            rxd_in = (k % 2 == 0) ? 8'hD0 : 8'h10;
            step(10);
        end
        chk("alt_link_speed", link_speed, 2'b01);
        chk("alt_full_duplex", full_duplex, 0);
        chk("alt_speed", speed, 0);
        chk("alt_dp_cycles", dp_total - dp0, 0);
        rxd_in = 8'h30;
        step(20);

        // Reset asserted while in SWAP
        force_en    = 1'b1;
        force_speed = 2'b10;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step(1);
            seen = dp_reset;
        end
        chk("swap_dp_rise_seen", seen, 1);
        step(8);
        chk("swap_speed_latched", speed, 1);
        chk("swap_dp_reset", dp_reset, 1);
        reset = 1'b1;
        #1;
        chk("midrst_speed", speed, 0);
        chk("midrst_dp_reset", dp_reset, 1);
        chk("midrst_link_up", link_up, 0);
        chk("midrst_status_valid", status_valid, 0);
        force_en = 1'b0;
        rxd_in   = 8'h30;
        step(2);
        reset = 1'b0;
        dp0 = dp_total;
        sc0 = sc_total;
        step(60);
        chk("recov_dp_cycles", dp_total - dp0, 8);
        chk("recov_no_pulse", sc_total - sc0, 0);
        chk("recov_link_up", link_up, 1);
        chk("recov_link_speed", link_speed, 2'b01);
        chk("recov_status_valid", status_valid, 1);
        chk("recov_speed", speed, 0);

        // 1000M committed but frames every 40 cycles keep the switch waiting
        rxd_in = 8'hD0;
        dp0 = dp_total;
        sc0 = sc_total;
        step(30);
        for (int k = 0; k < 5; k++) begin
            rxdv_in = 1'b1;
            rxd_in  = 8'h55;
            step(4);
            rxdv_in = 1'b0;
            rxd_in  = 8'hD0;
            step(36);
        end
        chk("frames_link_speed", link_speed, 2'b10);
        chk("frames_speed", speed, 0);
        chk("frames_dp_cycles", dp_total - dp0, 0);
        step(120);
        chk("gap_speed", speed, 1);
        chk("gap_dp_cycles", dp_total - dp0, 17);
        chk("gap_pulses", sc_total - sc0, 1);
        chk("pulse_width", sc_double, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
